counter_nb_updown_mod: RTL and testbench

//   Parametrised synchronous up/down counter for the SimpleProcessor datapath.

---
 rtl/counter_nb_updown_mod.sv | 75 +++++++
 tb/tb_counter_nb_updown_mod.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/counter_nb_updown_mod.sv
// Parametrised up/down counter with modulus, load, synchronous clear and wrap/saturate.
// Provides a combinational cascade terminal count and a registered wrap pulse.
module counter_nb_updown_mod #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned INIT     = 0
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_sclr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_input,
    input  logic             i_en,
    input  logic             i_up,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_wrap
);

    localparam int unsigned      CW       = WIDTH + 1;
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);
    localparam logic [CW-1:0]    MOD_EXT  = CW'(MODULUS);

    logic             at_max;
    logic             at_min;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;

    assign at_max = (o_count == MAX_VAL);
    assign at_min = (o_count == '0);

    // Cascade terminal count: ignores sclr/load so chained stages see the carry early
    assign o_tc = i_en & ((i_up & at_max) | (~i_up & at_min));

    // Next-state selection, priority sclr > load > enable
    always_comb begin
        count_nxt = o_count;
        wrap_nxt  = 1'b0;
        if (i_sclr) begin
            count_nxt = '0;
        end else if (i_load) begin
            // Extended compare so MODULUS == 2**WIDTH never clamps
            count_nxt = ({1'b0, i_input} >= MOD_EXT) ? MAX_VAL : i_input;
        end else if (i_en) begin
            if (i_up) begin
                if (!at_max) begin
                    count_nxt = o_count + WIDTH'(1);
                end else if (SATURATE == 0) begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                if (!at_min) begin
                    count_nxt = o_count - WIDTH'(1);
                end else if (SATURATE == 0) begin
                    count_nxt = MAX_VAL;
                    wrap_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            o_count <= INIT_VAL;
            o_wrap  <= 1'b0;
        end else begin
            o_count <= count_nxt;
            o_wrap  <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_counter_nb_updown_mod.sv
// Scoreboard bench: randomized and directed stimulus against an arithmetic reference model
// for wrap, saturate, tiny-modulus and two-stage cascade configurations.
module tb_counter_nb_updown_mod;

    logic       clk  = 1'b0;
    logic       clr  = 1'b0;
    logic       sclr = 1'b0;
    logic       load = 1'b0;
    logic       en   = 1'b0;
    logic       up   = 1'b0;
    logic       cen  = 1'b0;
    logic [3:0] din  = 4'd0;

    logic [3:0] w_cnt, s_cnt, c0_cnt, c1_cnt;
    logic [1:0] m_cnt;
    logic       w_tc, w_wrap, s_tc, s_wrap, m_tc, m_wrap;
    logic       c0_tc, c0_wrap, c1_tc, c1_wrap;

    always #5 clk = ~clk;

    counter_nb_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .INIT(3)) u_w (
        .i_clk(clk), .i_clr(clr), .i_sclr(sclr), .i_load(load), .i_input(din),
        .i_en(en), .i_up(up), .o_count(w_cnt), .o_tc(w_tc), .o_wrap(w_wrap));

    counter_nb_updown_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(1), .INIT(0)) u_s (
        .i_clk(clk), .i_clr(clr), .i_sclr(sclr), .i_load(load), .i_input(din),
        .i_en(en), .i_up(up), .o_count(s_cnt), .o_tc(s_tc), .o_wrap(s_wrap));

    counter_nb_updown_mod #(.WIDTH(2), .MODULUS(2), .SATURATE(0), .INIT(1)) u_m (
        .i_clk(clk), .i_clr(clr), .i_sclr(sclr), .i_load(load), .i_input(din[1:0]),
        .i_en(en), .i_up(up), .o_count(m_cnt), .o_tc(m_tc), .o_wrap(m_wrap));

    counter_nb_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .INIT(0)) u_c0 (
        .i_clk(clk), .i_clr(clr), .i_sclr(1'b0), .i_load(1'b0), .i_input(4'd0),
        .i_en(cen), .i_up(1'b1), .o_count(c0_cnt), .o_tc(c0_tc), .o_wrap(c0_wrap));

    counter_nb_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .INIT(0)) u_c1 (
        .i_clk(clk), .i_clr(clr), .i_sclr(1'b0), .i_load(1'b0), .i_input(4'd0),
        .i_en(c0_tc), .i_up(1'b1), .o_count(c1_cnt), .o_tc(c1_tc), .o_wrap(c1_wrap));

    typedef struct {
        int w_tc, w_cnt, w_wr;
        int s_tc, s_cnt, s_wr;
        int m_tc, m_cnt, m_wr;
        int c_tot, c0_tc, c1_tc, c0_wr, c1_wr;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    int w_c = 3, s_c = 0, m_c = 1, tot = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int tc_of(input int c, input int m, input logic e, input logic u);
        return (e && ((u && c == m - 1) || (!u && c == 0))) ? 1 : 0;
    endfunction

    task automatic step(input int c, input int m, input int sat, input logic sc, input logic ld,
                        input int d, input logic e, input logic u, output int nc, output int nw);
        nc = c;
        nw = 0;
        if (sc) nc = 0;
        else if (ld) nc = (d > m - 1) ? m - 1 : d;
        else if (e && u) begin
            if (c < m - 1) nc = c + 1;
            else if (sat == 0) begin nc = 0; nw = 1; end
        end else if (e) begin
            if (c > 0) nc = c - 1;
            else if (sat == 0) begin nc = m - 1; nw = 1; end
        end
    endtask

    // Apply one cycle of stimulus and queue the response it must produce
    task automatic drive(input logic sc, input logic ld, input logic [3:0] d,
                         input logic e, input logic u, input logic ce);
        exp_t r;
        int   nc, nw;
        @(negedge clk);
        sclr = sc; load = ld; din = d; en = e; up = u; cen = ce;
        r.w_tc = tc_of(w_c, 10, e, u);
        step(w_c, 10, 0, sc, ld, int'(d), e, u, nc, nw);
        r.w_cnt = nc; r.w_wr = nw; w_c = nc;
        r.s_tc = tc_of(s_c, 16, e, u);
        step(s_c, 16, 1, sc, ld, int'(d), e, u, nc, nw);
        r.s_cnt = nc; r.s_wr = nw; s_c = nc;
        r.m_tc = tc_of(m_c, 2, e, u);
        step(m_c, 2, 0, sc, ld, int'(d) % 4, e, u, nc, nw);
        r.m_cnt = nc; r.m_wr = nw; m_c = nc;
        r.c0_tc = (ce && tot % 10 == 9) ? 1 : 0;
        r.c1_tc = 0;
        r.c0_wr = r.c0_tc;
        r.c1_wr = (ce && tot == 99) ? 1 : 0;
        tot     = ce ? (tot + 1) % 100 : tot;
        r.c_tot = tot;
        q.push_back(r);
    endtask

    // Asynchronous clear between edges; outputs must change without a clock
    task automatic clr_pulse();
        @(posedge clk);
        #3 clr = 1'b1;
        #1;
        w_c = 3; s_c = 0; m_c = 1; tot = 0;
        chk("clr_w_cnt", int'(w_cnt), 3);
        chk("clr_w_wrap", int'(w_wrap), 0);
        chk("clr_s_cnt", int'(s_cnt), 0);
        chk("clr_m_cnt", int'(m_cnt), 1);
        chk("clr_m_wrap", int'(m_wrap), 0);
        chk("clr_c_tot", int'(c1_cnt) * 10 + int'(c0_cnt), 0);
        clr = 1'b0;
    endtask

    // Monitor: tc sampled mid-cycle, registered outputs just after the edge
    initial begin
        exp_t e;
        int   a_wtc, a_stc, a_mtc, a_c0tc, a_c1tc;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                a_wtc = int'(w_tc); a_stc = int'(s_tc); a_mtc = int'(m_tc);
                a_c0tc = int'(c0_tc); a_c1tc = int'(c1_tc);
                e = q[0];
                e.c1_tc = (a_c0tc == 1 && e.c_tot == 0) ? 1 : 0;
                @(posedge clk);
                #1;
                void'(q.pop_front());
                chk("w_tc", a_wtc, e.w_tc);
                chk("w_cnt", int'(w_cnt), e.w_cnt);
                chk("w_wrap", int'(w_wrap), e.w_wr);
                chk("s_tc", a_stc, e.s_tc);
                chk("s_cnt", int'(s_cnt), e.s_cnt);
                chk("s_wrap", int'(s_wrap), e.s_wr);
                chk("m_tc", a_mtc, e.m_tc);
                chk("m_cnt", int'(m_cnt), e.m_cnt);
                chk("m_wrap", int'(m_wrap), e.m_wr);
                chk("c0_tc", a_c0tc, e.c0_tc);
                chk("c1_tc", a_c1tc, e.c1_wr);
                chk("c_total", int'(c1_cnt) * 10 + int'(c0_cnt), e.c_tot);
                chk("c0_wrap", int'(c0_wrap), e.c0_wr);
                chk("c1_wrap", int'(c1_wrap), e.c1_wr);
            end
        end
    end

    initial begin
        #1 clr = 1'b1; en = 1'b1; up = 1'b1; cen = 1'b1;
        #2;
        chk("rst_w_cnt", int'(w_cnt), 3);
        chk("rst_w_wrap", int'(w_wrap), 0);
        chk("rst_m_cnt", int'(m_cnt), 1);
        #4;
        chk("rst_hold_w_cnt", int'(w_cnt), 3);
        chk("rst_hold_s_cnt", int'(s_cnt), 0);
        chk("rst_hold_c_tot", int'(c1_cnt) * 10 + int'(c0_cnt), 0);
        #1 clr = 1'b0;

        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        repeat (12) drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        repeat (12) drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 4'd12, 1'b1, 1'b1, 1'b1);
        repeat (4) drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        clr_pulse();

        repeat (600) begin
            drive(1'($urandom_range(15) == 0), 1'($urandom_range(7) == 0),
                  4'($urandom_range(15)), 1'($urandom_range(3) != 0),
                  1'($urandom_range(1)), 1'($urandom_range(4) != 0));
            if ($urandom_range(40) == 0) clr_pulse();
        end

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #3;
        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
